mux_scan_n: RTL and testbench
=============================

Name: mux_scan_n

Overview:
- Parametrised, registered N:1 multiplexer for W-bit channels.
- Two operating modes:
  - manual: the channel comes from the `sel` input.
  - scan: an internal sequencer steps through channels 0..N-1, holding each one for DWELL cycles.
- Sits between multi-channel sources (switches, sensors, counters) and a single downstream consumer such as an LED/display driver or serial TX.
- Provides change and wrap strobes so the consumer knows which channel `z` carries.

Parameters:
- W, 1, data width per channel (>=1).
- N, 8, number of channels (2..2^SW).
- SW, 3, width of `sel`/`ch`; 2^SW >= N required.
- DWELL, 4, cycles spent on each channel in scan mode (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  clock enable; 0 freezes all state.
- mode  in  1  0 = manual, 1 = scan.
- sel  in  SW  channel request in manual mode.
- d  in  N*W  flattened channel data; channel k occupies bits [k*W +: W].
- z  out  W  registered selected data.
- ch  out  SW  current channel index (registered).
- stb  out  1  one-cycle pulse on the cycle `ch` changes.
- wrap  out  1  one-cycle pulse when scan steps N-1 -> 0.
- bad_sel  out  1  one-cycle pulse when manual `sel` >= N.

Behaviour:
- Reset: the reset is synchronous and active-high. With rst=1 at a clk edge: z=0, ch=0, dwell counter cnt=0, stb=0, wrap=0, bad_sel=0. rst has priority over en.
- Data path: on each edge with en=1, z <= d[ch*W +: W], using `ch` as it was before the edge.
  - Latency: one cycle from `ch` to `z`.
  - After `ch` changes at edge k, `z` shows the new channel's data from edge k+1.
- en=0: z, ch and cnt hold; stb, wrap and bad_sel are 0.
- Manual mode (mode=0, en=1):
  - sel < N and sel != ch: ch <= sel, stb=1.
  - sel == ch: no change, stb=0.
  - sel >= N: ch holds, bad_sel=1, stb=0.
  - cnt is held at 0.
- Scan mode (mode=1, en=1):
  - cnt counts 0..DWELL-1.
  - When cnt == DWELL-1: cnt <= 0, ch <= (ch == N-1) ? 0 : ch+1, stb=1. wrap=1 only on the N-1 -> 0 step.
  - Otherwise cnt <= cnt+1.
  - `sel` is ignored and bad_sel=0.
  - DWELL=1: ch advances every enabled cycle.
- Mode switch manual->scan: on the first scan cycle cnt starts from 0 and the scan continues from the current ch. The first step happens DWELL cycles later.
- Mode switch scan->manual: cnt is cleared; ch takes sel on that same edge per the manual rules.
- cnt width is clog2(DWELL) bits, minimum 1; it never exceeds DWELL-1.
- Out-of-range ch is unreachable: ch only ever loads values < N.
- A reset asserted mid-dwell or mid-scan aborts immediately; after reset, scanning resumes at channel 0 with a full dwell.

Decomposition:
- Shared header mux_defs.vh holds MODE_MANUAL=1'b0, MODE_SCAN=1'b1, and a clog2 function/macro used for the cnt width.
- One natural sub-module, muxn_comb: a purely combinational parametrised (W, N, SW) selector from d/ch to a W-bit result. Out-of-range index returns 0.
- mux_scan_n instantiates muxn_comb and adds the registers, the dwell counter and the strobe logic.

Test Plan (W=4, N=8, SW=3, DWELL=3; d = {4'h7,4'h6,...,4'h0}, i.e. channel k = k):
- Reset: hold rst=1 for 2 cycles with mode=1, en=1 -> z=0, ch=0, stb=0, wrap=0, bad_sel=0; after release, the first step to ch=1 occurs on the 3rd enabled edge.
- Manual select: mode=0, sel=5 -> next edge ch=5, stb=1; following edge z=4'h5, stb=0. Holding sel=5 gives no further stb.
- Bad select: N=6 build, mode=0, ch=2, sel=7 -> ch stays 2, bad_sel=1 for one cycle, z stays 4'h2.
- Scan and wrap: mode=1 for 24 cycles -> ch sequence 0,0,0,1,1,1,...,7,7,7,0. stb pulses every 3 cycles; wrap=1 exactly on the 7 -> 0 step; z lags ch by one cycle.
- Enable freeze: in scan mode with ch=3 and cnt=1, drop en for 5 cycles -> ch, cnt and z frozen, strobes 0. After re-enable, ch -> 4 after exactly 2 more enabled cycles.
- Mode switch: scan at ch=6 with cnt=2, set mode=0 with sel=1 -> next edge ch=1, stb=1, cnt=0. Back to mode=1 -> ch=2 after 3 enabled cycles.

Source files
------------

// File: rtl/mux_scan_n_pkg.sv
// Shared definitions for the scanning N:1 multiplexer: mode encodings and
// the width helper used to size the dwell counter.
package mux_scan_n_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_scan_n_muxn_comb.sv
// Purely combinational N:1 selector over a flattened W-bit channel bus.
// An index at or beyond N yields zero.
module muxn_comb #(
  parameter int W  = 1,
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic [N*W-1:0] d,
  input  logic [SW-1:0]  idx,
  output logic [W-1:0]   y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(idx) == k) y = d[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N:1 multiplexer with manual channel select or a timed scan
// sequencer, plus change/wrap/bad-select strobes for the consumer.
module mux_scan_n
  import mux_scan_n_pkg::*;
#(
  parameter int W     = 1,
  parameter int N     = 8,
  parameter int SW    = 3,
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] d,
  output logic [W-1:0]   z,
  output logic [SW-1:0]  ch,
  output logic           stb,
  output logic           wrap,
  output logic           bad_sel
);

  localparam int              CW        = clog2_min1(DWELL);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(DWELL - 1);
  localparam logic [SW-1:0]   CH_LAST   = SW'(N - 1);
  localparam logic [SW:0]     SEL_LIMIT = (SW+1)'(N);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [SW-1:0] ch_nxt;
  logic          stb_nxt;
  logic          wrap_nxt;
  logic          bad_nxt;
  logic [W-1:0]  sel_data;

  muxn_comb #(
    .W  (W),
    .N  (N),
    .SW (SW)
  ) u_sel (
    .d   (d),
    .idx (ch),
    .y   (sel_data)
  );

  always_comb begin
    ch_nxt   = ch;
    cnt_nxt  = cnt;
    stb_nxt  = 1'b0;
    wrap_nxt = 1'b0;
    bad_nxt  = 1'b0;
    if (en) begin
      if (mode == MODE_SCAN) begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          stb_nxt = 1'b1;
          if (ch == CH_LAST) begin
            ch_nxt   = '0;
            wrap_nxt = 1'b1;
          end else begin
            ch_nxt = ch + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else begin
        // Manual mode keeps the dwell counter cleared so a later scan
        // always begins with a full dwell on the current channel.
        cnt_nxt = '0;
        if ({1'b0, sel} >= SEL_LIMIT) begin
          bad_nxt = 1'b1;
        end else if (sel != ch) begin
          ch_nxt  = sel;
          stb_nxt = 1'b1;
        end
      end
    end
  end

  // Stage p0: channel state, strobes and the selected data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch      <= '0;
      cnt     <= '0;
      stb     <= 1'b0;
      wrap    <= 1'b0;
      bad_sel <= 1'b0;
      z       <= '0;
    end else begin
      ch      <= ch_nxt;
      cnt     <= cnt_nxt;
      stb     <= stb_nxt;
      wrap    <= wrap_nxt;
      bad_sel <= bad_nxt;
      if (en) z <= sel_data;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: directed vector table, an N=6 bad-select sequence,
// and randomized traffic against a behavioural model on N=8 and N=6 builds.
module tb_mux_scan_n;

  localparam int W  = 4;
  localparam int SW = 3;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst, en, mode;
  logic [SW-1:0] sel;
  logic [31:0]   d8;
  logic [23:0]   d6;
  logic [W-1:0]  z8, z6;
  logic [SW-1:0] ch8, ch6;
  logic          stb8, wrap8, bad8, stb6, wrap6, bad6;

  assign d6 = d8[23:0];

  always #5 clk = ~clk;

  mux_scan_n #(.W(W), .N(8), .SW(SW), .DWELL(DW)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .d(d8),
    .z(z8), .ch(ch8), .stb(stb8), .wrap(wrap8), .bad_sel(bad8)
  );

  mux_scan_n #(.W(W), .N(6), .SW(SW), .DWELL(DW)) dut6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .d(d6),
    .z(z6), .ch(ch6), .stb(stb6), .wrap(wrap6), .bad_sel(bad6)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       rst, en, mode;
    logic [2:0] sel;
    int         ch, z;
    logic       stb, wrap, bad;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic m, input int s,
                     input int c, input int zz, input logic st, input logic wr, input logic bd);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.sel = 3'(s);
    v.ch = c; v.z = zz; v.stb = st; v.wrap = wr; v.bad = bd;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model, one entry per build (0: N=8, 1: N=6).
  int m_ch[2], m_cnt[2], m_z[2], m_stb[2], m_wrap[2], m_bad[2];

  task automatic model_step(input int k, input int n);
    if (rst) begin
      m_ch[k] = 0; m_cnt[k] = 0; m_z[k] = 0;
      m_stb[k] = 0; m_wrap[k] = 0; m_bad[k] = 0;
    end else begin
      m_stb[k] = 0; m_wrap[k] = 0; m_bad[k] = 0;
      if (en) begin
        m_z[k] = (m_ch[k] < n) ? int'((d8 >> (m_ch[k] * W)) & 32'hF) : 0;
        if (mode) begin
          if (m_cnt[k] == DW - 1) begin
            m_cnt[k] = 0;
            m_ch[k]  = (m_ch[k] + 1) % n;
            m_stb[k] = 1;
            m_wrap[k] = (m_ch[k] == 0) ? 1 : 0;
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end else begin
          m_cnt[k] = 0;
          if (int'(sel) >= n) m_bad[k] = 1;
          else if (int'(sel) != m_ch[k]) begin
            m_ch[k] = int'(sel);
            m_stb[k] = 1;
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b1; sel = '0; d8 = 32'h7654_3210;

    // Reset then scan: ch = floor(i/3) mod 8, z lags ch by one edge.
    add(1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 34; i++)
      add(0, 1, 1, 0, (i / 3) % 8, ((i - 1) / 3) % 8, (i % 3) == 0, (i % 24) == 0, 0);
    // Freeze at ch=3, cnt=1.
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 3, 3, 0, 0, 0);
    for (int i = 35; i <= 44; i++)
      add(0, 1, 1, 0, (i / 3) % 8, ((i - 1) / 3) % 8, (i % 3) == 0, (i % 24) == 0, 0);
    // Scan at ch=6 cnt=2 -> manual sel=1, then back to scan.
    add(0, 1, 0, 1, 1, 6, 1, 0, 0);
    add(0, 1, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, 1, 0, 2, 1, 1, 0, 0);
    // Manual select 5 and hold.
    add(0, 1, 0, 5, 5, 2, 1, 0, 0);
    add(0, 1, 0, 5, 5, 5, 0, 0, 0);
    add(0, 1, 0, 5, 5, 5, 0, 0, 0);
    add(0, 1, 0, 7, 7, 5, 1, 0, 0);
    // Reset wins over en=0.
    add(1, 0, 0, 7, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; mode = tbl[i].mode; sel = tbl[i].sel;
      tick();
      check($sformatf("tbl%0d.ch", i), int'(ch8), tbl[i].ch);
      check($sformatf("tbl%0d.z", i), int'(z8), tbl[i].z);
      check($sformatf("tbl%0d.stb", i), int'(stb8), int'(tbl[i].stb));
      check($sformatf("tbl%0d.wrap", i), int'(wrap8), int'(tbl[i].wrap));
      check($sformatf("tbl%0d.bad", i), int'(bad8), int'(tbl[i].bad));
    end

    // N=6 build: out-of-range manual select.
    rst = 1'b1; en = 1'b1; mode = 1'b0; sel = 3'd2;
    tick();
    rst = 1'b0;
    tick();
    check("n6.ch_load", int'(ch6), 2);
    check("n6.stb_load", int'(stb6), 1);
    tick();
    check("n6.z_load", int'(z6), 2);
    check("n6.stb_hold", int'(stb6), 0);
    sel = 3'd7;
    tick();
    check("n6.bad_ch", int'(ch6), 2);
    check("n6.bad_pulse", int'(bad6), 1);
    check("n6.bad_stb", int'(stb6), 0);
    check("n6.bad_z", int'(z6), 2);
    sel = 3'd2;
    tick();
    check("n6.bad_clear", int'(bad6), 0);
    check("n6.bad_ch2", int'(ch6), 2);

    // Randomized traffic against the model, both builds.
    for (int i = 0; i < 3000; i++) begin
      rst  = (i == 0) || ($urandom_range(0, 59) == 0);
      en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      sel  = 3'($urandom_range(0, 7));
      d8   = $urandom;
      model_step(0, 8);
      model_step(1, 6);
      tick();
      check("rnd8.ch", int'(ch8), m_ch[0]);
      check("rnd8.z", int'(z8), m_z[0]);
      check("rnd8.stb", int'(stb8), m_stb[0]);
      check("rnd8.wrap", int'(wrap8), m_wrap[0]);
      check("rnd8.bad", int'(bad8), m_bad[0]);
      check("rnd6.ch", int'(ch6), m_ch[1]);
      check("rnd6.z", int'(z6), m_z[1]);
      check("rnd6.stb", int'(stb6), m_stb[1]);
      check("rnd6.wrap", int'(wrap6), m_wrap[1]);
      check("rnd6.bad", int'(bad6), m_bad[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
